// File: rtl/dcache_dual_arbiter.sv
// Program-order arbiter from the two memory slots of a dual-issue pair onto one data-cache port,
// with a tag FIFO that routes in-order responses back. Optional perf counters: DCACHE_ARB_PERF_EN.
module dcache_dual_arbiter #(
  parameter int OUTSTD_DEPTH = 4,
  parameter int PTR_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_01,
  input  logic        wr_01,
  input  logic [1:0]  size_01,
  input  logic [31:0] addr_01,
  input  logic [3:0]  wstrb_01,
  input  logic [31:0] wdata_01,
  input  logic        req_02,
  input  logic        wr_02,
  input  logic [1:0]  size_02,
  input  logic [31:0] addr_02,
  input  logic [3:0]  wstrb_02,
  input  logic [31:0] wdata_02,
  output logic        addr_ok_01,
  output logic        addr_ok_02,
  output logic        data_ok_01,
  output logic        data_ok_02,
  output logic [31:0] rdata_01,
  output logic [31:0] rdata_02,
  output logic        cache_req,
  output logic        cache_wr,
  output logic [1:0]  cache_size,
  output logic [31:0] cache_addr,
  output logic [3:0]  cache_wstrb,
  output logic [31:0] cache_wdata,
  input  logic        cache_addr_ok,
  input  logic        cache_data_ok,
  input  logic [31:0] cache_rdata
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_full_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD1 = 2'd1,
    S_HOLD2 = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic                    any_req;
  logic                    req_raw;
  logic                    grant_2;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    head_tag;
  logic [PTR_W:0]          count_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [OUTSTD_DEPTH-1:0] tag_reg;
  logic [OUTSTD_DEPTH-1:0] tag_next;

  assign any_req    = req_01 | req_02;
  assign fifo_full  = (count_reg == (PTR_W+1)'(OUTSTD_DEPTH));
  assign fifo_empty = (count_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant is locked from the first cycle cache_req is raised until the cache takes it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cache_req && !cache_addr_ok) begin
          state_next = grant_2 ? S_HOLD2 : S_HOLD1;
        end
      end
      S_HOLD1, S_HOLD2: begin
        if (cache_req && cache_addr_ok) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_raw = 1'b0;
    grant_2 = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_raw = any_req;
        grant_2 = ~req_01;
      end
      S_HOLD1: begin
        req_raw = 1'b1;
        grant_2 = 1'b0;
      end
      S_HOLD2: begin
        req_raw = 1'b1;
        grant_2 = 1'b1;
      end
      default: begin
        req_raw = 1'b0;
        grant_2 = 1'b0;
      end
    endcase
  end

  assign cache_req   = req_raw & ~fifo_full;
  assign cache_wr    = grant_2 ? wr_02    : wr_01;
  assign cache_size  = grant_2 ? size_02  : size_01;
  assign cache_addr  = grant_2 ? addr_02  : addr_01;
  assign cache_wstrb = grant_2 ? wstrb_02 : wstrb_01;
  assign cache_wdata = grant_2 ? wdata_02 : wdata_01;

  assign push       = cache_req & cache_addr_ok;
  assign addr_ok_01 = push & ~grant_2;
  assign addr_ok_02 = push &  grant_2;

  // A response with nothing outstanding is simply dropped.
  assign pop        = cache_data_ok & ~fifo_empty;
  assign head_tag   = tag_reg[rd_ptr_reg];
  assign data_ok_01 = pop & ~head_tag;
  assign data_ok_02 = pop &  head_tag;
  assign rdata_01   = cache_rdata;
  assign rdata_02   = cache_rdata;

  // Tag FIFO entries: 0 = slot 01, 1 = slot 02.
  for (genvar gi = 0; gi < OUTSTD_DEPTH; gi++) begin : g_tag
    assign tag_next[gi] = (push && (wr_ptr_reg == PTR_W'(gi))) ? grant_2 : tag_reg[gi];
  end

  always_ff @(posedge clk) begin
    tag_reg <= tag_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(cache_data_ok && fifo_empty))
        else $warning("dcache_dual_arbiter: cache response with no outstanding request dropped");
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_conflict_reg;
  logic [31:0] perf_full_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_reg <= '0;
      perf_full_reg     <= '0;
    end else begin
      if (req_01 && req_02 && (perf_conflict_reg != '1)) begin
        perf_conflict_reg <= perf_conflict_reg + 32'd1;
      end
      if (any_req && fifo_full && (perf_full_reg != '1)) begin
        perf_full_reg <= perf_full_reg + 32'd1;
      end
    end
  end

  assign perf_conflict_cnt = perf_conflict_reg;
  assign perf_full_cnt     = perf_full_reg;
`endif

endmodule

// File: tb/tb_dcache_dual_arbiter.sv
// Directed bench for dcache_dual_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_dcache_dual_arbiter;

  logic        clk;
  logic        reset;
  logic        req_01, wr_01, req_02, wr_02;
  logic [1:0]  size_01, size_02;
  logic [31:0] addr_01, addr_02, wdata_01, wdata_02;
  logic [3:0]  wstrb_01, wstrb_02;
  logic        addr_ok_01, addr_ok_02, data_ok_01, data_ok_02;
  logic [31:0] rdata_01, rdata_02;
  logic        cache_req, cache_wr;
  logic [1:0]  cache_size;
  logic [31:0] cache_addr, cache_wdata;
  logic [3:0]  cache_wstrb;
  logic        cache_addr_ok, cache_data_ok;
  logic [31:0] cache_rdata;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_full_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  dcache_dual_arbiter dut (
    .clk(clk), .reset(reset),
    .req_01(req_01), .wr_01(wr_01), .size_01(size_01), .addr_01(addr_01),
    .wstrb_01(wstrb_01), .wdata_01(wdata_01),
    .req_02(req_02), .wr_02(wr_02), .size_02(size_02), .addr_02(addr_02),
    .wstrb_02(wstrb_02), .wdata_02(wdata_02),
    .addr_ok_01(addr_ok_01), .addr_ok_02(addr_ok_02),
    .data_ok_01(data_ok_01), .data_ok_02(data_ok_02),
    .rdata_01(rdata_01), .rdata_02(rdata_02),
    .cache_req(cache_req), .cache_wr(cache_wr), .cache_size(cache_size),
    .cache_addr(cache_addr), .cache_wstrb(cache_wstrb), .cache_wdata(cache_wdata),
    .cache_addr_ok(cache_addr_ok), .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata)
`ifdef DCACHE_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of outstanding slot numbers plus the slot whose request is pending.
  int q[$];
  int lock = 0;
  int m_conflict = 0;
  int m_full = 0;

  initial begin
    int  want, tmp;
    bit  full, e_req, e_ok1, e_ok2, e_dok1, e_dok2;
    forever begin
      @(negedge clk);
      e_ok1 = 0; e_ok2 = 0; full = 0;
      if (!reset) begin
        full   = (q.size() == 4);
        want   = (lock != 0) ? lock : (req_01 ? 1 : (req_02 ? 2 : 0));
        e_req  = (want != 0) && !full;
        e_ok1  = e_req && cache_addr_ok && (want == 1);
        e_ok2  = e_req && cache_addr_ok && (want == 2);
        e_dok1 = cache_data_ok && (q.size() > 0) && (q[0] == 1);
        e_dok2 = cache_data_ok && (q.size() > 0) && (q[0] == 2);
        check("m_cache_req", {31'd0, cache_req}, {31'd0, e_req});
        check("m_addr_ok_01", {31'd0, addr_ok_01}, {31'd0, e_ok1});
        check("m_addr_ok_02", {31'd0, addr_ok_02}, {31'd0, e_ok2});
        check("m_data_ok_01", {31'd0, data_ok_01}, {31'd0, e_dok1});
        check("m_data_ok_02", {31'd0, data_ok_02}, {31'd0, e_dok2});
        if (e_req) begin
          check("m_cache_addr", cache_addr, (want == 2) ? addr_02 : addr_01);
          check("m_cache_wr", {31'd0, cache_wr}, {31'd0, (want == 2) ? wr_02 : wr_01});
          check("m_cache_size", {30'd0, cache_size}, {30'd0, (want == 2) ? size_02 : size_01});
          check("m_cache_wstrb", {28'd0, cache_wstrb}, {28'd0, (want == 2) ? wstrb_02 : wstrb_01});
          check("m_cache_wdata", cache_wdata, (want == 2) ? wdata_02 : wdata_01);
        end
        if (e_dok1) check("m_rdata_01", rdata_01, cache_rdata);
        if (e_dok2) check("m_rdata_02", rdata_02, cache_rdata);
`ifdef DCACHE_ARB_PERF_EN
        check("m_perf_conflict", perf_conflict_cnt, m_conflict);
        check("m_perf_full", perf_full_cnt, m_full);
`endif
        if (e_ok1 || e_ok2)
          $display("[TB] t=%0t accept slot%0d addr=%h", $time, want, cache_addr);
        if (e_dok1 || e_dok2)
          $display("[TB] t=%0t response slot%0d rdata=%h", $time, q[0], cache_rdata);
      end
      @(posedge clk);
      if (reset) begin
        q.delete();
        lock = 0;
        m_conflict = 0;
        m_full = 0;
      end else begin
        if (cache_data_ok && q.size() > 0) tmp = q.pop_front();
        if (e_ok1) q.push_back(1);
        if (e_ok2) q.push_back(2);
        if (e_req && cache_addr_ok) lock = 0;
        else if (e_req) lock = want;
        if (req_01 && req_02) m_conflict++;
        if ((req_01 || req_02) && full) m_full++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_01 = 0; wr_01 = 0; size_01 = 2'd2; addr_01 = 32'h1000_0010;
    wstrb_01 = 4'hf; wdata_01 = 32'hA1A1_A1A1;
    req_02 = 0; wr_02 = 0; size_02 = 2'd1; addr_02 = 32'h2000_0022;
    wstrb_02 = 4'hc; wdata_02 = 32'hB2B2_0000;
    cache_addr_ok = 0; cache_data_ok = 0; cache_rdata = 32'h0;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cache_req", {31'd0, cache_req}, 32'd0);
    check("rst_addr_ok", {30'd0, addr_ok_01, addr_ok_02}, 32'd0);
    check("rst_data_ok", {30'd0, data_ok_01, data_ok_02}, 32'd0);
    cyc();

    // 1: dual loads, both accepted back to back, responses in order
    req_01 = 1; req_02 = 1; cache_addr_ok = 1;
    @(negedge clk);
    check("t1_addr_ok_01_c0", {31'd0, addr_ok_01}, 32'd1);
    check("t1_addr_ok_02_c0", {31'd0, addr_ok_02}, 32'd0);
    cyc();
    req_01 = 0;
    @(negedge clk);
    check("t1_addr_ok_02_c1", {31'd0, addr_ok_02}, 32'd1);
    check("t1_addr_c1", cache_addr, 32'h2000_0022);
    cyc();
    req_02 = 0; cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'h1111_1111;
    @(negedge clk);
    check("t1_data_ok_01", {30'd0, data_ok_01, data_ok_02}, 32'd2);
    check("t1_rdata_01", rdata_01, 32'h1111_1111);
    cyc();
    cache_rdata = 32'h2222_2222;
    @(negedge clk);
    check("t1_data_ok_02", {30'd0, data_ok_01, data_ok_02}, 32'd1);
    check("t1_rdata_02", rdata_02, 32'h2222_2222);
    cyc();
    cache_data_ok = 0;

    // 2: slot 02 grant locked while slot 01 arrives
    wr_02 = 1;
    req_02 = 1;
    @(negedge clk);
    check("t2_addr_c0", cache_addr, 32'h2000_0022);
    cyc();
    req_01 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_addr_locked", cache_addr, 32'h2000_0022);
      check("t2_no_ok_01", {31'd0, addr_ok_01}, 32'd0);
      cyc();
    end
    cache_addr_ok = 1;
    @(negedge clk);
    check("t2_ok_02", {30'd0, addr_ok_01, addr_ok_02}, 32'd1);
    cyc();
    req_02 = 0;
    @(negedge clk);
    check("t2_ok_01_after", {30'd0, addr_ok_01, addr_ok_02}, 32'd2);
    check("t2_addr_01", cache_addr, 32'h1000_0010);
    cyc();
    req_01 = 0; cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'h0202_0202;
    @(negedge clk);
    check("t2_resp_02_first", {30'd0, data_ok_01, data_ok_02}, 32'd1);
    cyc();
    cache_rdata = 32'h0101_0101;
    @(negedge clk);
    check("t2_resp_01_second", {30'd0, data_ok_01, data_ok_02}, 32'd2);
    cyc();
    cache_data_ok = 0;

    // 3: four outstanding fill the FIFO; 5th waits until the cycle after a response
    req_01 = 1; cache_addr_ok = 1;
    repeat (4) cyc();
    @(negedge clk);
    check("t3_full_blocks", {31'd0, cache_req}, 32'd0);
    cyc();
    cache_data_ok = 1; cache_rdata = 32'h3333_3333;
    @(negedge clk);
    check("t3_no_same_cycle", {31'd0, cache_req}, 32'd0);
    check("t3_pop_01", {31'd0, data_ok_01}, 32'd1);
    cyc();
    cache_data_ok = 0;
    @(negedge clk);
    check("t3_accept_next", {31'd0, addr_ok_01}, 32'd1);
    cyc();
    req_01 = 0; cache_addr_ok = 0;

    // 4: drain to 2, then simultaneous push/pop across the pointer wrap
    cache_data_ok = 1;
    repeat (2) cyc();
    cache_addr_ok = 1; req_02 = 1;
    @(negedge clk);
    check("t4_a", {28'd0, addr_ok_01, addr_ok_02, data_ok_01, data_ok_02}, 32'b0110);
    cyc();
    req_02 = 0; req_01 = 1;
    @(negedge clk);
    check("t4_b", {28'd0, addr_ok_01, addr_ok_02, data_ok_01, data_ok_02}, 32'b1010);
    cyc();
    req_01 = 0; req_02 = 1;
    @(negedge clk);
    check("t4_c", {28'd0, addr_ok_01, addr_ok_02, data_ok_01, data_ok_02}, 32'b0101);
    cyc();
    req_02 = 0; cache_addr_ok = 0;
    @(negedge clk);
    check("t4_drain_01", {30'd0, data_ok_01, data_ok_02}, 32'd2);
    cyc();
    @(negedge clk);
    check("t4_drain_02", {30'd0, data_ok_01, data_ok_02}, 32'd1);
    cyc();
    @(negedge clk);
    check("t4_empty", {30'd0, data_ok_01, data_ok_02}, 32'd0);
    cyc();
    cache_data_ok = 0;

    // 5: reset with 3 outstanding and slot 01 held
    req_01 = 1; cache_addr_ok = 1;
    repeat (3) cyc();
    cache_addr_ok = 0;
    cyc();
    req_01 = 0; reset = 1;
    cyc();
    reset = 0; req_02 = 1; cache_data_ok = 1;
    @(negedge clk);
    check("t5_no_data_ok", {30'd0, data_ok_01, data_ok_02}, 32'd0);
    check("t5_idle_regrant", cache_addr, 32'h2000_0022);
    check("t5_cache_req", {31'd0, cache_req}, 32'd1);
    cyc();
    cache_data_ok = 0; cache_addr_ok = 1;
    @(negedge clk);
    check("t5_ok_02", {31'd0, addr_ok_02}, 32'd1);
    cyc();
    req_02 = 0; cache_addr_ok = 0; cache_data_ok = 1;
    @(negedge clk);
    check("t5_resp_02", {30'd0, data_ok_01, data_ok_02}, 32'd1);
    cyc();
    cache_data_ok = 0;

`ifdef DCACHE_ARB_PERF_EN
    // 6: perf counters over 5 dual-request cycles, FIFO full for the last 2
    reset = 1;
    cyc();
    reset = 0; req_01 = 1; cache_addr_ok = 1;
    cyc();
    req_02 = 1;
    repeat (5) cyc();
    req_01 = 0; req_02 = 0; cache_addr_ok = 0;
    @(negedge clk);
    check("t6_perf_conflict", perf_conflict_cnt, 32'd5);
    check("t6_perf_full", perf_full_cnt, 32'd2);
    cyc();
`endif

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
